// File: rtl/call_latch.sv
// Hall and car call latches for an 8-floor elevator: each raw button is synchronized,
// debounced, and latched until the controller services that floor or power drops.
module call_latch #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic [7:0] up_btn,
  input  logic [7:0] down_btn,
  input  logic [7:0] car_btn,
  input  logic [3:0] status,
  input  logic [2:0] floor,
  input  logic       nextup,
  input  logic       nextdown,
  output logic [7:0] upcall,
  output logic [7:0] downcall,
  output logic [7:0] floor_btn,
  output logic       pending,
  output logic       req_above,
  output logic       req_below
);

  localparam logic [3:0] DEB = 4'(DEB_CYCLES);
  localparam logic [3:0] ST_SHUTDOWN = 4'd0;
  localparam logic [3:0] ST_OPENING  = 4'd6;

  // Bit order of the 24 raw inputs: [7:0] up, [15:8] down, [23:16] car.
  logic [23:0] raw;
  logic [23:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]  cnt_q [24];
  logic [3:0]  cnt_d [24];
  logic [23:0] press;

  logic [7:0] up_q, up_d, down_q, down_d, car_q, car_d;
  logic [7:0] floor_hot, clr_up, clr_down, clr_car;
  logic       svc, kill;

  assign raw = {car_btn, down_btn, up_btn};

  // Counter saturates at DEB, so the press fires only on the cycle it first gets there.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    press   = '0;
    for (int i = 0; i < 24; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i]) begin
        cnt_d[i] = (cnt_q[i] == DEB) ? cnt_q[i] : cnt_q[i] + 4'd1;
        press[i] = (cnt_q[i] == DEB - 4'd1);
      end
    end
  end

  always_comb begin
    kill      = !power || (status == ST_SHUTDOWN);
    svc       = power && (status == ST_OPENING);
    floor_hot = 8'b1 << floor;
    clr_car   = svc ? floor_hot : 8'h00;
    clr_up    = (svc && (nextup || !nextdown)) ? floor_hot : 8'h00;
    clr_down  = (svc && (nextdown || !nextup)) ? floor_hot : 8'h00;
    // Clear is applied after the press OR so a same-edge press on a serviced bit loses.
    up_d   = (up_q   | press[7:0])   & ~clr_up   & 8'h7F;
    down_d = (down_q | press[15:8])  & ~clr_down & 8'hFE;
    car_d  = (car_q  | press[23:16]) & ~clr_car;
    if (kill) begin
      up_d   = 8'h00;
      down_d = 8'h00;
      car_d  = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      up_q    <= '0;
      down_q  <= '0;
      car_q   <= '0;
      for (int i = 0; i < 24; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      up_q    <= up_d;
      down_q  <= down_d;
      car_q   <= car_d;
      for (int i = 0; i < 24; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Outputs are forced low for the whole time rst is held, not only after its first edge.
  assign upcall    = up_q   & {8{~rst}};
  assign downcall  = down_q & {8{~rst}};
  assign floor_btn = car_q  & {8{~rst}};

  always_comb begin
    pending   = |{upcall, downcall, floor_btn};
    req_above = 1'b0;
    req_below = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (upcall[f] || downcall[f] || floor_btn[f]) begin
        if (f > int'(floor)) req_above = 1'b1;
        if (f < int'(floor)) req_below = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_call_latch.sv
// Bench for call_latch: directed scenarios then random traffic, all outputs compared
// every cycle against a run-length reference model of debounce and latching.
module tb_call_latch;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       power;
  logic [7:0] up_btn, down_btn, car_btn;
  logic [3:0] status;
  logic [2:0] floor;
  logic       nextup, nextdown;
  logic [7:0] upcall, downcall, floor_btn;
  logic       pending, req_above, req_below;

  int n_checks = 0;
  int n_err    = 0;

  logic [26:0] exp_q[$];

  // Reference model state: raw history two edges deep and length of the current high run.
  logic h1 [24];
  logic h2 [24];
  int   run [24];
  logic [7:0] mu, md, mc;

  call_latch #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .power(power),
    .up_btn(up_btn), .down_btn(down_btn), .car_btn(car_btn),
    .status(status), .floor(floor), .nextup(nextup), .nextdown(nextdown),
    .upcall(upcall), .downcall(downcall), .floor_btn(floor_btn),
    .pending(pending), .req_above(req_above), .req_below(req_below)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_edge();
    logic [23:0] rawv;
    logic [23:0] ev;
    rawv = {car_btn, down_btn, up_btn};
    ev   = '0;
    if (rst) begin
      for (int i = 0; i < 24; i++) begin
        h1[i] = 1'b0; h2[i] = 1'b0; run[i] = 0;
      end
      mu = '0; md = '0; mc = '0;
    end else begin
      for (int i = 0; i < 24; i++) begin
        run[i] = h2[i] ? run[i] + 1 : 0;
        ev[i]  = (run[i] == DEB);
        h2[i]  = h1[i];
        h1[i]  = rawv[i];
      end
      if (!power || status == 4'd0) begin
        mu = '0; md = '0; mc = '0;
      end else begin
        for (int f = 0; f < 8; f++) begin
          if (f != 7 && ev[f])      mu[f] = 1'b1;
          if (f != 0 && ev[8 + f])  md[f] = 1'b1;
          if (ev[16 + f])           mc[f] = 1'b1;
        end
        if (status == 4'd6) begin
          mc[floor] = 1'b0;
          if (nextup || !nextdown) mu[floor] = 1'b0;
          if (nextdown || !nextup) md[floor] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [26:0] model_out();
    logic [7:0] any;
    logic ab, be;
    if (rst) return '0;
    any = mu | md | mc;
    ab = 1'b0; be = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (any[f] && f > int'(floor)) ab = 1'b1;
      if (any[f] && f < int'(floor)) be = 1'b1;
    end
    return {mu, md, mc, |any, ab, be};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [26:0] e;
    e = exp_q.pop_front();
    chk("upcall",    upcall,           e[26:19]);
    chk("downcall",  downcall,         e[18:11]);
    chk("floor_btn", floor_btn,        e[10:3]);
    chk("pending",   {7'd0, pending},   {7'd0, e[2]});
    chk("req_above", {7'd0, req_above}, {7'd0, e[1]});
    chk("req_below", {7'd0, req_below}, {7'd0, e[0]});
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; power = 1'b1; status = 4'd1; floor = 3'd0;
    nextup = 1'b0; nextdown = 1'b0;
    up_btn = '0; down_btn = '0; car_btn = '0;
    for (int i = 0; i < 24; i++) begin h1[i] = 1'b0; h2[i] = 1'b0; run[i] = 0; end
    mu = '0; md = '0; mc = '0;
    @(negedge clk);
    steps(2);
    chk("reset_pending", {7'd0, pending}, 8'h00);
    rst = 1'b0;

    // Debounce latency on car_btn[5]
    floor = 3'd2;
    car_btn[5] = 1'b1;
    steps(5);
    chk("latency_edge5", floor_btn, 8'h00);
    step();
    chk("latency_edge6", floor_btn, 8'h20);
    chk("latency_pending", {7'd0, pending}, 8'h01);
    chk("latency_above", {7'd0, req_above}, 8'h01);
    chk("latency_below", {7'd0, req_below}, 8'h00);
    car_btn[5] = 1'b0;

    // Bounce: 3 high / 1 low never qualifies
    for (int k = 0; k < 40; k++) begin
      up_btn[3] = (k % 4) != 3;
      step();
    end
    up_btn[3] = 1'b0;
    steps(3);
    chk("bounce_upcall", upcall, 8'h00);

    // Directional clear at floor 4
    up_btn[4] = 1'b1; down_btn[4] = 1'b1;
    steps(7);
    up_btn[4] = 1'b0; down_btn[4] = 1'b0;
    chk("dir_set_up", upcall, 8'h10);
    chk("dir_set_down", downcall, 8'h10);
    floor = 3'd4; status = 4'd6; nextup = 1'b1; nextdown = 1'b0;
    step();
    chk("dir_clear_up", upcall, 8'h00);
    chk("dir_keep_down", downcall, 8'h10);

    // Service floor 5 to drop the earlier car call
    floor = 3'd5; nextup = 1'b0;
    step();
    status = 4'd1;

    // Clear wins over a same-edge press; other bits still latch
    car_btn[2] = 1'b1; car_btn[6] = 1'b1;
    steps(5);
    floor = 3'd2; status = 4'd6;
    step();
    chk("clear_wins", floor_btn, 8'h40);
    status = 4'd1;
    car_btn[2] = 1'b0; car_btn[6] = 1'b0;

    // Power loss with three latches set, then ignored up_btn[7]
    up_btn[1] = 1'b1;
    steps(7);
    up_btn[1] = 1'b0;
    step();
    chk("three_set_up", upcall, 8'h02);
    power = 1'b0;
    step();
    chk("pwr_up", upcall, 8'h00);
    chk("pwr_down", downcall, 8'h00);
    chk("pwr_car", floor_btn, 8'h00);
    chk("pwr_pending", {7'd0, pending}, 8'h00);
    power = 1'b1;
    up_btn[7] = 1'b1;
    steps(20);
    chk("ignored_up7", upcall, 8'h00);
    up_btn[7] = 1'b0;

    // Reset mid-debounce on down_btn[6]
    down_btn[6] = 1'b1;
    steps(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(5);
    chk("rst_mid_edge5", downcall, 8'h00);
    step();
    chk("rst_mid_edge6", downcall, 8'h40);
    down_btn[6] = 1'b0;

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) up_btn[b]   = ~up_btn[b];
        if ($urandom_range(0, 7) == 0) down_btn[b] = ~down_btn[b];
        if ($urandom_range(0, 7) == 0) car_btn[b]  = ~car_btn[b];
      end
      case ($urandom_range(0, 19))
        0:       status = 4'd0;
        1, 2, 3: status = 4'd6;
        default: status = 4'($urandom_range(7, 15));
      endcase
      power    = ($urandom_range(0, 40) != 0);
      rst      = ($urandom_range(0, 150) == 0);
      floor    = 3'($urandom_range(0, 7));
      nextup   = 1'($urandom_range(0, 1));
      nextdown = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
